// File: rtl/lsu_rmw.sv
`timescale 1ns/1ps
// lsu_rmw: load/store unit that turns RV32 byte/half/word loads and stores into
// full-word RAM accesses. Loads get lane extraction plus sign/zero extension;
// sub-word stores do a read-modify-write because RAM byte enables are fixed.
// One request in flight; lsu_busy is high outside IDLE and lsu_done pulses for
// one cycle. Load latency is 3 cycles after the accept edge, SW is 2, SB/SH is 4.
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   lsu_req/wen/funct3/addr/wdata   request from execute (sampled in IDLE only)
//   lsu_busy/done/rdata/err  status and load result toward the core
//   ram_addr/wen/width/store word-wide RAM request (synchronous-read RAM)
//   ram_load                 RAM read data, valid one cycle after ram_addr
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W and illegal funct3 skip
// the RAM and complete one cycle after accept with lsu_err = 1. Without it,
// misaligned addresses are rounded down and lsu_err is tied to 0.
module lsu_rmw #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [1:0]        ram_width,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_wen;
  logic [15:0]       r_wdata;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_sign;
  logic              w_accept;
  logic              w_trap;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_merge;

  assign w_accept = (r_state == S_IDLE) && lsu_req;

  // Width decode. Illegal encodings (011, 11x, BU/HU as a store) fall through
  // to word width. The lane offset drops address bits that a wider access
  // ignores, which is what rounds a misaligned address down.
  always_comb begin
    w_size = SZ_W;
    w_sign = 1'b0;
    w_off  = 2'b00;
    case (lsu_funct3)
      3'b000: begin w_size = SZ_B; w_sign = 1'b1; end
      3'b001: begin w_size = SZ_H; w_sign = 1'b1; end
      3'b100: if (!lsu_wen) w_size = SZ_B;
      3'b101: if (!lsu_wen) w_size = SZ_H;
      default: ;
    endcase
    case (w_size)
      SZ_B:    w_off = lsu_addr[1:0];
      SZ_H:    w_off = {lsu_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_illegal;
  logic w_misal;
  logic r_err;

  assign w_illegal = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11) ||
                     (lsu_wen && lsu_funct3[2] && !lsu_funct3[1]);
  assign w_misal   = ((w_size == SZ_H) && lsu_addr[0]) ||
                     ((w_size == SZ_W) && (lsu_addr[1:0] != 2'b00));
  assign w_trap    = w_illegal || w_misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_trap;
  end
`else
  assign w_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. Full-word stores need no read, so they go straight to WR.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (lsu_req) begin
          if (w_trap)                         w_next = S_DONE;
          else if (lsu_wen && w_size == SZ_W) w_next = S_WR;
          else                                w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: w_next = S_RD_DATA;
      S_RD_DATA: w_next = r_wen ? S_WR : S_DONE;
      S_WR:      w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads (ram_load is valid during RD_DATA)
  always_comb begin
    w_byte = ram_load[7:0];
    case (r_off)
      2'd1:    w_byte = ram_load[15:8];
      2'd2:    w_byte = ram_load[23:16];
      2'd3:    w_byte = ram_load[31:24];
      default: w_byte = ram_load[7:0];
    endcase
    w_half = r_off[1] ? ram_load[31:16] : ram_load[15:0];
    case (r_size)
      SZ_B:    w_load_ext = {{24{r_sign & w_byte[7]}}, w_byte};
      SZ_H:    w_load_ext = {{16{r_sign & w_half[15]}}, w_half};
      default: w_load_ext = ram_load;
    endcase
  end

  // Store merge: overlay the new byte/half on the word just read back
  always_comb begin
    w_merge = ram_load;
    if (r_size == SZ_B) begin
      case (r_off)
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: ;
      endcase
    end else if (r_size == SZ_H) begin
      if (r_off[1]) w_merge[31:16] = r_wdata;
      else          w_merge[15:0]  = r_wdata;
    end
  end

  // Request capture and datapath registers. r_store is preloaded with the
  // full store word at accept so a SW can go straight to WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_size  <= SZ_W;
      r_sign  <= 1'b0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_store <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
        r_off   <= w_off;
        r_size  <= w_size;
        r_sign  <= w_sign;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata[15:0];
        r_store <= lsu_wdata;
      end
      if (r_state == S_RD_DATA) begin
        if (r_wen) r_store <= w_merge;
        else       r_rdata <= w_load_ext;
      end
    end
  end

  // Outputs
  always_comb begin
    lsu_busy  = (r_state != S_IDLE);
    lsu_done  = (r_state == S_DONE);
    ram_wen   = (r_state == S_WR);
    ram_width = 2'b10;
    ram_addr  = r_addr;
    ram_store = r_store;
    lsu_rdata = r_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    lsu_err   = r_err && (r_state == S_DONE);
`else
    lsu_err   = 1'b0;
`endif
  end

endmodule
